push_rs232rx_cfg: RTL

Parametrised RS-232 receiver. It generalises the existing push receiver to 5-9 data bits, optional odd/even parity and 1 or 2 stop bits. It adds start-bit validation, parity/framing/break detection and consumer-driven RTS flow control.
It sits between the board RXD pin and a push-style consumer (no backpressure on the data path). One received frame produces exactly one ostrobe pulse.

---
 rtl/rs232_pkg.sv | 23 ++
 rtl/rs232_baud_gen.sv | 36 +++
 rtl/push_rs232rx_cfg.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: parity modes, receiver state encoding and the
// baud reload helper used by the receiver (and later the transmitter).
package rs232_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PAR     = 3'd3,
        STOP    = 3'd4,
        BRKWAIT = 3'd5
    } rx_state_t;

    // Rounded number of clocks per (fraction of a) bit.
    function automatic int baud_count(input real freq, input real rate, input real frac);
        return int'(frac * freq / rate);
    endfunction

endpackage

// File: rtl/rs232_baud_gen.sv
// Free-running bit-period counter. tick pulses for one cycle on expiry;
// load_half restarts the count so the next tick lands mid-bit.
module rs232_baud_gen #(
    parameter int FULL = 16,
    parameter int HALF = 8
) (
    input  logic clock,
    input  logic resetn,
    input  logic load_half,
    output logic tick
);

    localparam int CW = $clog2(FULL) + 1;

    if (FULL < 4) begin : g_full_check
        $error("rs232_baud_gen: FULL must be at least 4");
    end

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(1));

    // A start detection that coincides with expiry takes the half load.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= CW'(FULL);
        end else if (load_half) begin
            cnt_q <= CW'(HALF);
        end else if (tick) begin
            cnt_q <= CW'(FULL);
        end else begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/push_rs232rx_cfg.sv
// Configurable RS-232 receiver with parity/framing/break flags, pushing one
// strobe per frame to a consumer, and RTS driven from the consumer's ready.
module push_rs232rx_cfg
    import rs232_pkg::*;
#(
    parameter real CLOCK_FREQ = 133000000.0,
    parameter real BAUD_RATE  = 115200.0,
    parameter int  DATA_BITS  = 8,
    parameter int  PARITY     = 0,
    parameter int  STOP_BITS  = 1
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 rxd_pin,
    input  logic                 iready,
    output logic                 rtsn_pin,
    output logic [DATA_BITS-1:0] odata,
    output logic                 ostrobe,
    output logic                 operr,
    output logic                 oferr,
    output logic                 obreak,
    output logic [2:0]           dbg_state
);

    localparam int FULL = baud_count(CLOCK_FREQ, BAUD_RATE, 1.0);
    localparam int HALF = baud_count(CLOCK_FREQ, BAUD_RATE, 0.5);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
        $error("push_rs232rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_parity_check
        $error("push_rs232rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
        $error("push_rs232rx_cfg: STOP_BITS must be 1 or 2");
    end

    logic                 rxd_meta_q;
    logic                 rxd_q;
    logic                 rtsn_q;
    rx_state_t            state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [3:0]           bit_idx_q;
    logic                 stop_idx_q;
    logic                 par_q;
    logic                 stop0_q;
    logic                 ferr_q;
    logic [DATA_BITS-1:0] odata_q;
    logic                 ostrobe_q;
    logic                 operr_q;
    logic                 oferr_q;
    logic                 obreak_q;

    logic tick;
    logic load_half;
    logic par_xor;
    logic perr_d;
    logic ferr_d;
    logic brk_d;
    logic first_stop;
    logic last_stop;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rxd_meta_q <= 1'b1;
            rxd_q      <= 1'b1;
            rtsn_q     <= 1'b1;
        end else begin
            rxd_meta_q <= rxd_pin;
            rxd_q      <= rxd_meta_q;
            rtsn_q     <= ~iready;
        end
    end

    assign load_half = (state_q == IDLE) && !rxd_q;

    rs232_baud_gen #(
        .FULL (FULL),
        .HALF (HALF)
    ) u_baud (
        .clock     (clock),
        .resetn    (resetn),
        .load_half (load_half),
        .tick      (tick)
    );

    // Frame verdicts, evaluated on the final stop tick with the live sample.
    assign par_xor    = (^shift_q) ^ par_q;
    assign perr_d     = (PARITY == PARITY_ODD)  ? ~par_xor :
                        (PARITY == PARITY_EVEN) ?  par_xor : 1'b0;
    assign ferr_d     = ferr_q | ~rxd_q;
    assign first_stop = stop_idx_q ? stop0_q : rxd_q;
    assign brk_d      = (shift_q == '0) && ((PARITY == PARITY_NONE) || !par_q) && !first_stop;
    assign last_stop  = (STOP_BITS == 1) || stop_idx_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
            stop0_q    <= 1'b1;
            ferr_q     <= 1'b0;
            odata_q    <= '0;
            ostrobe_q  <= 1'b0;
            operr_q    <= 1'b0;
            oferr_q    <= 1'b0;
            obreak_q   <= 1'b0;
        end else begin
            ostrobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rxd_q) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rxd_q) begin
                            state_q <= IDLE;
                        end else begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q <= {rxd_q, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == 4'(DATA_BITS - 1)) begin
                            state_q    <= (PARITY != PARITY_NONE) ? PAR : STOP;
                            stop_idx_q <= 1'b0;
                            ferr_q     <= 1'b0;
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end
                end
                PAR: begin
                    if (tick) begin
                        par_q   <= rxd_q;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (last_stop) begin
                            ostrobe_q <= 1'b1;
                            odata_q   <= shift_q;
                            operr_q   <= perr_d;
                            oferr_q   <= ferr_d;
                            obreak_q  <= brk_d;
                            state_q   <= brk_d ? BRKWAIT : IDLE;
                        end else begin
                            stop0_q    <= rxd_q;
                            ferr_q     <= ferr_d;
                            stop_idx_q <= 1'b1;
                        end
                    end
                end
                BRKWAIT: begin
                    if (rxd_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rtsn_pin  = rtsn_q;
    assign odata     = odata_q;
    assign ostrobe   = ostrobe_q;
    assign operr     = operr_q;
    assign oferr     = oferr_q;
    assign obreak    = obreak_q;
    assign dbg_state = state_q;

endmodule
